// File: rtl/melody_player.sv
// rtl/melody_player.sv - step sequencer feeding the notes ROM / PWM modulator
//
// Walks a pattern ROM of {duration, note} entries, holds each note for
// `duration` beat strobes and drives the note index plus a gate.
//
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   strb_i            1-cycle beat strobe
//   start_i, stop_i   start/restart at entry 0, abort (stop wins)
//   loop_i            wrap to entry 0 at end of pattern instead of finishing
//   legato_i          1 = gate held through the last beat of a note
//   step_data_i       pattern ROM data {duration, note}, combinational from step_addr_o
//   step_addr_o       current pattern entry
//   noteIndex_o       note index to the notes ROM
//   gate_o            sound enable
//   busy_o            high in LOAD/PLAY
//   done_o            1-cycle pulse at natural end of the pattern
module melody_player #(
  parameter int IDX_BW  = 6,
  parameter int DUR_BW  = 4,
  parameter int ADDR_BW = 6,
  parameter int SEQ_LEN = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     strb_i,
  input  logic                     start_i,
  input  logic                     stop_i,
  input  logic                     loop_i,
  input  logic                     legato_i,
  input  logic [IDX_BW+DUR_BW-1:0] step_data_i,
  output logic [ADDR_BW-1:0]       step_addr_o,
  output logic [IDX_BW-1:0]        noteIndex_o,
  output logic                     gate_o,
  output logic                     busy_o,
  output logic                     done_o
);

  typedef enum logic [1:0] {IDLE, LOAD, PLAY, FINISH} state_t;

  localparam logic [ADDR_BW-1:0] LAST_STEP = ADDR_BW'(SEQ_LEN - 1);

  state_t              state, state_n;
  logic [ADDR_BW-1:0]  step, step_n;
  logic [IDX_BW-1:0]   note, note_n;
  logic [DUR_BW-1:0]   dur_cnt, dur_n;

  logic [IDX_BW-1:0]   rom_note;
  logic [DUR_BW-1:0]   rom_dur;

  assign rom_note = step_data_i[IDX_BW-1:0];
  assign rom_dur  = step_data_i[IDX_BW+DUR_BW-1:IDX_BW];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      step    <= '0;
      note    <= '0;
      dur_cnt <= '0;
    end else begin
      state   <= state_n;
      step    <= step_n;
      note    <= note_n;
      dur_cnt <= dur_n;
    end
  end

  always_comb begin
    state_n = state;
    step_n  = step;
    note_n  = note;
    dur_n   = dur_cnt;
    if (stop_i) begin
      // step/note deliberately kept so the last position stays observable
      state_n = IDLE;
    end else if (start_i) begin
      step_n  = '0;
      state_n = LOAD;
    end else begin
      case (state)
        IDLE: ;
        LOAD: begin
          if (rom_dur == '0) begin
            // terminator; wrapping only from a non-zero entry avoids an
            // endless LOAD loop on an empty pattern
            if (step != '0 && loop_i) step_n = '0;
            else                      state_n = FINISH;
          end else begin
            note_n  = rom_note;
            dur_n   = rom_dur;
            state_n = PLAY;
          end
        end
        PLAY: begin
          if (strb_i) begin
            if (dur_cnt > DUR_BW'(1)) begin
              dur_n = dur_cnt - DUR_BW'(1);
            end else if (step == LAST_STEP) begin
              if (loop_i) begin
                step_n  = '0;
                state_n = LOAD;
              end else begin
                state_n = FINISH;
              end
            end else begin
              step_n  = step + ADDR_BW'(1);
              state_n = LOAD;
            end
          end
        end
        FINISH:  state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  assign step_addr_o = step;
  assign noteIndex_o = note;
  // note 0 is a rest; staccato drops the gate during the final beat
  assign gate_o      = (state == PLAY) && (note != '0) &&
                       (legato_i || dur_cnt != DUR_BW'(1));
  assign busy_o      = (state == LOAD) || (state == PLAY);
  assign done_o      = (state == FINISH);

endmodule
